// File: rtl/mips_pkg.sv
// Definitions shared by the fetch stage and the control unit of the single-cycle MIPS datapath.
// Holds the fetch state encoding, instruction field positions and opcode values.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetchState_t;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int WORD_SHIFT = 2;

    localparam logic [5:0] OP_R   = 6'd0;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_SW  = 6'd43;
    localparam logic [5:0] OP_BEQ = 6'd4;

    // Signed word offset (beq immediate) turned into a byte displacement.
    function automatic logic [31:0] branchDisp(input logic [15:0] offset);
        logic [31:0] extended;
        extended = {{16{offset[15]}}, offset};
        return extended << WORD_SHIFT;
    endfunction

endpackage

// File: rtl/instruction_fetch_next_pc.sv
// Sequential and branch-target address computation for the fetch stage.
// All arithmetic is modulo 2^32, so 32'hFFFF_FFFC + 4 wraps to zero.
module next_pc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branchTaken,
    input  logic [15:0] branchOffset,
    output logic [31:0] nextPc,
    output logic [31:0] pcPlus4
);

    assign pcPlus4 = pc + 32'd4;
    assign nextPc  = branchTaken ? pcPlus4 + branchDisp(branchOffset) : pcPlus4;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, fetches one word per instruction from instruction memory
// and hands it to decode over a valid/ready handshake, redirecting on flush.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imemReq,
    output logic [31:0]          imemAddr,
    input  logic                 imemAck,
    input  logic [INSTR_W-1:0]   imemData,
    output logic                 instrValid,
    input  logic                 instrReady,
    output logic [INSTR_W-1:0]   instr,
    output logic [5:0]           opCode,
    output logic [31:0]          pcOut,
    output logic [31:0]          pcPlus4,
    input  logic                 branchTaken,
    input  logic [15:0]          branchOffset,
    input  logic                 flush,
    input  logic [31:0]          flushPc,
    output logic [31:0]          retiredCount
);

    fetchState_t        state, stateNext;
    logic [31:0]        pc, pcNext;
    logic [INSTR_W-1:0] instrReg, instrNext;
    logic [31:0]        retiredNext;
    logic               pendingFlush, pendingFlushNext;
    logic [31:0]        pendingPc, pendingPcNext;
    logic [31:0]        branchPc;
    logic [31:0]        alignedFlushPc;

    assign alignedFlushPc = flushPc & ~32'h3;

    next_pc uNextPc (
        .pc           (pc),
        .branchTaken  (branchTaken),
        .branchOffset (branchOffset),
        .nextPc       (branchPc),
        .pcPlus4      (pcPlus4)
    );

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values computed below, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            instrReg     <= '0;
            retiredCount <= '0;
            pendingFlush <= 1'b0;
            pendingPc    <= RESET_PC;
        end else begin
            state        <= stateNext;
            pc           <= pcNext;
            instrReg     <= instrNext;
            retiredCount <= retiredNext;
            pendingFlush <= pendingFlushNext;
            pendingPc    <= pendingPcNext;
        end
    end

    // NOTE: every signal written here gets a hold/default value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        stateNext        = state;
        pcNext           = pc;
        instrNext        = instrReg;
        retiredNext      = retiredCount;
        pendingFlushNext = pendingFlush;
        pendingPcNext    = pendingPc;
        imemReq          = 1'b0;
        instrValid       = 1'b0;

        case (state)
            IDLE: begin
                stateNext = REQ;
                if (flush) pcNext = alignedFlushPc;
            end
            REQ: begin
                imemReq = 1'b1;
                if (imemAck) begin
                    // A flush seen now or earlier in this request discards the returned word.
                    if (flush) begin
                        pcNext           = alignedFlushPc;
                        pendingFlushNext = 1'b0;
                    end else if (pendingFlush) begin
                        pcNext           = pendingPc;
                        pendingFlushNext = 1'b0;
                    end else begin
                        instrNext = imemData;
                        stateNext = HOLD;
                    end
                end else if (flush) begin
                    pendingFlushNext = 1'b1;
                    pendingPcNext    = alignedFlushPc;
                end
            end
            HOLD: begin
                instrValid = 1'b1;
                if (flush) begin
                    pcNext    = alignedFlushPc;
                    stateNext = REQ;
                end else if (instrReady) begin
                    pcNext      = branchPc;
                    retiredNext = retiredCount + 32'd1;
                    stateNext   = REQ;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign imemAddr = pc;
    assign pcOut    = pc;
    assign instr    = instrReg;
    assign opCode   = instrReg[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, wait states, backpressure,
// branches, deferred and coincident flushes, PC wrap and asynchronous reset.
module tb_instruction_fetch;
    import mips_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [5:0]  opCode;
    logic [31:0] pcOut;
    logic [31:0] pcPlus4;
    logic        branchTaken;
    logic [15:0] branchOffset;
    logic        flush;
    logic [31:0] flushPc;
    logic [31:0] retiredCount;

    int testCount = 0;
    int failCount = 0;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemAck      (imemAck),
        .imemData     (imemData),
        .instrValid   (instrValid),
        .instrReady   (instrReady),
        .instr        (instr),
        .opCode       (opCode),
        .pcOut        (pcOut),
        .pcPlus4      (pcPlus4),
        .branchTaken  (branchTaken),
        .branchOffset (branchOffset),
        .flush        (flush),
        .flushPc      (flushPc),
        .retiredCount (retiredCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: opcode chosen by address, low bits carry the address for traceability.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        case (addr)
            32'h0:   return {OP_R,  addr[25:0]};
            32'h4:   return {OP_LW, addr[25:0]};
            32'h8:   return {OP_SW, addr[25:0]};
            default: return {OP_BEQ, addr[25:0]};
        endcase
    endfunction

    assign imemData = memWord(imemAddr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        imemAck      = 1'b1;
        instrReady   = 1'b1;
        branchTaken  = 1'b0;
        branchOffset = 16'h0;
        flush        = 1'b0;
        flushPc      = 32'h0;

        // Reset state
        repeat (2) step();
        check("rst imemReq", 32'(imemReq), 32'd0);
        check("rst instrValid", 32'(instrValid), 32'd0);
        check("rst imemAddr", imemAddr, 32'h0);
        check("rst retired", retiredCount, 32'd0);
        check("rst instr", instr, 32'h0);

        // Zero-wait sequential fetch of 0, 4, 8
        rst_n = 1'b1;
        #1 check("idle imemReq", 32'(imemReq), 32'd0);
        step();
        check("seq req0", 32'(imemReq), 32'd1);
        check("seq addr0", imemAddr, 32'h0);
        step();
        check("seq valid0", 32'(instrValid), 32'd1);
        check("seq op0", 32'(opCode), 32'(OP_R));
        check("seq pcOut0", pcOut, 32'h0);
        check("seq pcPlus4_0", pcPlus4, 32'h4);
        step();
        check("seq addr4", imemAddr, 32'h4);
        check("seq retired1", retiredCount, 32'd1);
        step();
        check("seq op1", 32'(opCode), 32'(OP_LW));
        check("seq pcOut1", pcOut, 32'h4);
        step();
        check("seq addr8", imemAddr, 32'h8);
        step();
        check("seq op2", 32'(opCode), 32'(OP_SW));
        step();
        check("seq addrC", imemAddr, 32'hC);
        check("seq retired3", retiredCount, 32'd3);

        // Memory wait states, then decode backpressure
        imemAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait req", 32'(imemReq), 32'd1);
            check("wait addr", imemAddr, 32'hC);
        end
        instrReady = 1'b0;
        imemAck    = 1'b1;
        step();
        check("bp valid", 32'(instrValid), 32'd1);
        check("bp instr", instr, memWord(32'hC));
        imemAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp hold valid", 32'(instrValid), 32'd1);
            check("bp hold instr", instr, memWord(32'hC));
            check("bp hold pcOut", pcOut, 32'hC);
            check("bp hold retired", retiredCount, 32'd3);
        end
        instrReady = 1'b1;
        imemAck    = 1'b1;
        step();
        check("bp next addr", imemAddr, 32'h10);
        check("bp retired", retiredCount, 32'd4);

        // Taken branches from pc 0x10 with offsets -2 and +3
        step();
        check("br pcOut", pcOut, 32'h10);
        branchTaken  = 1'b1;
        branchOffset = 16'hFFFE;
        step();
        check("br back addr", imemAddr, 32'hC);
        check("br back retired", retiredCount, 32'd5);
        branchTaken  = 1'b0;
        branchOffset = 16'h1234;
        step();
        step();
        check("br nt addr", imemAddr, 32'h10);
        step();
        branchTaken  = 1'b1;
        branchOffset = 16'h0003;
        step();
        check("br fwd addr", imemAddr, 32'h20);
        check("br retired", retiredCount, 32'd7);
        branchTaken  = 1'b0;
        branchOffset = 16'h0;

        // Deferred flush during a pending request; the later flush target wins
        imemAck = 1'b0;
        flush   = 1'b1;
        flushPc = 32'h300;
        step();
        check("fr addr stable1", imemAddr, 32'h20);
        flushPc = 32'h100;
        step();
        check("fr addr stable2", imemAddr, 32'h20);
        flush = 1'b0;
        step();
        check("fr addr stable3", imemAddr, 32'h20);
        imemAck = 1'b1;
        step();
        check("fr discard valid", 32'(instrValid), 32'd0);
        check("fr redirect addr", imemAddr, 32'h100);
        check("fr redirect req", 32'(imemReq), 32'd1);
        step();
        check("fr pcOut", pcOut, 32'h100);
        check("fr instr", instr, memWord(32'h100));
        check("fr retired", retiredCount, 32'd7);

        // Flush coincident with consume, then flush coincident with ack
        flush   = 1'b1;
        flushPc = 32'h40;
        step();
        check("fc addr", imemAddr, 32'h40);
        check("fc retired", retiredCount, 32'd7);
        check("fc valid", 32'(instrValid), 32'd0);
        flushPc = 32'h80;
        step();
        check("fa addr", imemAddr, 32'h80);
        check("fa valid", 32'(instrValid), 32'd0);
        flush = 1'b0;
        step();
        check("fa pcOut", pcOut, 32'h80);

        // PC wrap; flush target low bits are ignored
        flush   = 1'b1;
        flushPc = 32'hFFFF_FFFF;
        step();
        check("wrap flush addr", imemAddr, 32'hFFFF_FFFC);
        flush = 1'b0;
        step();
        check("wrap pcPlus4", pcPlus4, 32'h0);
        step();
        check("wrap addr", imemAddr, 32'h0);
        check("wrap retired", retiredCount, 32'd8);

        // Asynchronous reset in the middle of a request
        step();
        step();
        check("ar addr pre", imemAddr, 32'h4);
        imemAck = 1'b0;
        step();
        check("ar req pre", 32'(imemReq), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar imemReq", 32'(imemReq), 32'd0);
        check("ar instrValid", 32'(instrValid), 32'd0);
        check("ar imemAddr", imemAddr, 32'h0);
        check("ar retired", retiredCount, 32'd0);
        step();
        check("ar held req", 32'(imemReq), 32'd0);
        rst_n   = 1'b1;
        imemAck = 1'b1;
        step();
        check("ar restart req", 32'(imemReq), 32'd1);
        check("ar restart addr", imemAddr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the single-cycle MIPS datapath, directly upstream of the control unit. It holds the program counter, fetches one 32-bit word per instruction from instruction memory over a request/acknowledge handshake, and presents it to decode with a valid/ready handshake. It exposes the opcode field to the control unit. It computes the next PC from the branch decision returned when decode consumes the instruction.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports (clock and reset first):
- clk  in  1  single clock for all state; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imemReq  out  1  fetch request to instruction memory.
- imemAddr  out  32  byte address of the fetch.
- imemAck  in  1  memory has returned imemData this cycle.
- imemData  in  32  instruction word; sampled only when imemReq and imemAck are both 1.
- instrValid  out  1  instr, opCode, pcOut and pcPlus4 are valid.
- instrReady  in  1  decode consumes the instruction this cycle.
- instr  out  32  fetched instruction word.
- opCode  out  6  instr[31:26], wired to the control unit.
- pcOut  out  32  address of instr.
- pcPlus4  out  32  pcOut + 4.
- branchTaken  in  1  sampled on consume: branch resolved taken.
- branchOffset  in  16  signed word offset (beq immediate); sampled on consume.
- flush  in  1  redirect fetch to flushPc.
- flushPc  in  32  redirect target; bits [1:0] ignored and treated as 0.
- retiredCount  out  32  number of consumed instructions.

## Operation
- The block has three states: IDLE, REQ and HOLD. A pendingFlush flag and a pendingPc register support deferred flushes.
- Reset values: state=IDLE, pc=RESET_PC, instr=0, retiredCount=0, pendingFlush=0. Outputs: imemReq=0, instrValid=0, imemAddr=RESET_PC.
- IDLE: the block moves to REQ unconditionally on the next edge. If flush is high in IDLE, pc<=flushPc.
- REQ:
  - imemReq=1 and imemAddr=pc. imemAddr stays stable until imemAck.
  - On imemAck with pendingFlush=0: instr<=imemData, state<=HOLD.
  - On imemAck with pendingFlush=1: the data is discarded, pc<=pendingPc, pendingFlush<=0, and the block stays in REQ.
  - flush in REQ never changes imemAddr mid-request. It sets pendingFlush=1 and pendingPc=flushPc, and a later flush overwrites pendingPc.
  - If flush and imemAck occur in the same cycle, the data is discarded and pc<=flushPc.
- HOLD:
  - instrValid=1. instr, pcOut and pcPlus4 are stable while instrReady=0.
  - Consume happens when instrValid&instrReady. On consume:
    - pc<=branchTaken ? pc+4+(sext(branchOffset)<<2) : pc+4
    - retiredCount++ (wraps at 2^32)
    - state<=REQ
  - flush in HOLD takes priority over a simultaneous consume. The instruction is dropped, retiredCount is unchanged, pc<=flushPc, and the state goes to REQ.
- Arithmetic: all PC arithmetic is 32-bit modulo 2^32. The sign extension is 16 bits to 32 bits, followed by a shift left by 2. 32'hFFFF_FFFC + 4 wraps to 0.
- Outputs are derived from the state registers:
  - imemReq = (state==REQ).
  - instrValid = (state==HOLD).
  - imemAddr = pcOut = pc; pcPlus4 = pc+4.
- If rst_n asserts mid-operation, all state returns to reset values immediately (asynchronously). Any outstanding memory request is abandoned.

## Timing
- After rst_n deasserts: IDLE for 1 cycle, then imemReq rises at the next edge.
- Zero-wait memory (imemAck in the same cycle as imemReq): instrValid rises 1 edge after the REQ cycle.
- Throughput is at best 1 instruction per 2 cycles (REQ, HOLD).
- Memory wait states extend REQ by one cycle per cycle without imemAck.
- A consume at edge N puts the new pc on imemAddr with imemReq=1 from edge N.
- branchTaken and branchOffset are used only in the consume cycle. They are don't-care otherwise.

## Structure
- Shared package (mips_pkg): state enum (IDLE, REQ, HOLD), OPCODE_MSB/LSB=31/26, INSTR_W=32, the word-shift constant, and the opcode constants shared with the control unit (R=0, LW=35, SW=43, BEQ=4).
- One natural sub-module is next_pc: a combinational adder and branch-target unit taking pc, branchTaken and branchOffset and producing nextPc and pcPlus4.

## Test plan
- Reset and zero-wait sequential fetch:
  - Stimulus: RESET_PC=0, imemAck always 1, instrReady always 1, memory returning opCode 0, 35, 43 at addresses 0, 4, 8.
  - Required response: imemAddr sequence 0, 4, 8 on alternate cycles; opCode 0, 35, 43; retiredCount=3.
- Wait states and backpressure:
  - Stimulus: imemAck delayed 3 cycles; instrReady held low 4 cycles.
  - Required response: imemAddr stable for the whole REQ period; instr and pcOut stable for the whole HOLD period; no double count in retiredCount.
- Branch taken:
  - Stimulus: at pc=0x10, branchTaken=1 with branchOffset=16'hFFFE.
  - Required response: next imemAddr=0x0C.
  - Stimulus: branchOffset=3.
  - Required response: next imemAddr=0x20.
- Flush during REQ with pending ack:
  - Stimulus: flushPc=0x100 asserted 2 cycles before imemAck.
  - Required response: the returned word is never valid; the next request is at 0x100.
- Flush coincident with consume in HOLD:
  - Required response: flush wins; retiredCount unchanged; next imemAddr=flushPc.
- Async reset asserted mid-REQ:
  - Required response: imemReq and instrValid drop without waiting for a clock edge; pc=RESET_PC.
- PC wrap:
  - Stimulus: pc=32'hFFFF_FFFC, not taken.
  - Required response: next imemAddr=0.
